ctrl_regs: RTL and testbench
============================

CTRL_REGS -- requirements
Module: ctrl_regs

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, command address width.
REQ-002 Parameter DATA_WIDTH, default 32, command data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd  input  2  command from initiator: 00 IDLE, 01 RD, 10 WR, 11 reserved.
REQ-006 cmd_addr  input  ADDR_WIDTH  register byte address.
REQ-007 cmd_data_w  input  DATA_WIDTH  write data.
REQ-008 cmd_data_r  output  DATA_WIDTH  registered read data.
REQ-009 cmd_err  output  1  one-cycle pulse on illegal access.
REQ-010 slv0_margin / slv1_margin / slv2_margin  input  8 each  per-channel FIFO free-space count.
REQ-011 slv0_en / slv1_en / slv2_en  output  1 each  channel enable, bit0 of the channel's RW register.
REQ-012 slv0_prio / slv1_prio / slv2_prio  output  2 each  arbitration priority, bits[2:1].
REQ-013 slv0_len / slv1_len / slv2_len  output  3 each  packet length code, bits[5:3].

Function
REQ-014 Address map:
- 0x00, 0x04, 0x08: SLV0/1/2 RW registers.
- 0x10, 0x14, 0x18: SLV0/1/2 RO status registers.
- Any other address is illegal.
REQ-015 WR to an RW address shall update that register's bits[5:0] from cmd_data_w[5:0] at the same clock edge; bits[31:6] are hardwired 0.
REQ-016 WR to an RO or illegal address shall leave all registers unchanged and pulse cmd_err for exactly one cycle, starting the cycle after the command.
REQ-017 Each RO register shall hold {24'h0, slvN_margin}, sampled into a flop every cycle.
- Reads return the margin value as of the cycle before the RD cycle.
REQ-018 RD shall load cmd_data_r at the edge ending the RD cycle, giving one-cycle read latency.
- cmd_data_r holds its value until the next RD.
- IDLE and WR do not change cmd_data_r.
REQ-019 RD to an illegal address shall load cmd_data_r with 0 and pulse cmd_err one cycle.
REQ-020 cmd 11 shall be treated as IDLE for register state and shall pulse cmd_err one cycle.
REQ-021 RD in the cycle directly after a WR to the same address shall return the newly written value.
REQ-022 Outputs slvN_en, slvN_prio and slvN_len shall be driven directly from the register flops, with no combinational path from cmd inputs.
REQ-023 The block accepts one command per cycle.
- Back-to-back commands are legal with no stall.
- No handshake or backpressure exists.

Reset
REQ-024 On rstn low:
- RW registers = 32'h0000_0007 (en=1, prio=3, len=0).
- RO registers = 32'h0000_0000.
- cmd_data_r = 0.
- cmd_err = 0.
REQ-025 Reset asserted mid-command shall abort the command with no register update.
- The first command is accepted on the first rising edge after rstn deasserts.

Structure
REQ-026 A shared package (mcdf_pkg) shall hold:
- the cmd encoding enum;
- the six address constants;
- the RW reset value;
- the field bit positions.
REQ-027 One natural sub-module, ctrl_reg_slice, shall be instantiated three times.
- Each instance holds one channel's RW and RO register.
- Each instance exposes the decoded fields.

Verification
REQ-028 Reset only, then RD 0x00 -> cmd_data_r = 32'h0000_0007 one cycle later; slv0_en=1, slv0_prio=3, slv0_len=0.
REQ-029 WR 0x04 with 32'hFFFF_FF2A, then RD 0x04 -> cmd_data_r = 32'h0000_002A; slv1_en=0, slv1_prio=1, slv1_len=5.
REQ-030 slv2_margin=8'h13 held, RD 0x18 -> cmd_data_r = 32'h0000_0013; WR 0x18 with 32'h55 -> cmd_err pulse, next RD still 32'h13.
REQ-031 RD 0x0C and cmd=11 -> cmd_err high one cycle each; RD 0x0C gives cmd_data_r = 0; all RW registers unchanged.
REQ-032 Back-to-back WR 0x08 = 32'h3F then RD 0x08 in consecutive cycles -> cmd_data_r = 32'h3F.
REQ-033 Assert rstn mid-sequence after WR 0x00 = 32'h00 -> slv0_en returns to 1 immediately (asynchronous), cmd_data_r = 0.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF control register block.
// Holds the command encoding, the register address map, the RW reset value
// and the RW field bit positions used by the top and the per-channel slice.
package mcdf_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RD   = 2'b01,
        CMD_WR   = 2'b10,
        CMD_RSV  = 2'b11
    } cmd_e;

    localparam logic [7:0] ADDR_SLV0_RW = 8'h00;
    localparam logic [7:0] ADDR_SLV1_RW = 8'h04;
    localparam logic [7:0] ADDR_SLV2_RW = 8'h08;
    localparam logic [7:0] ADDR_SLV0_RO = 8'h10;
    localparam logic [7:0] ADDR_SLV1_RO = 8'h14;
    localparam logic [7:0] ADDR_SLV2_RO = 8'h18;

    localparam int RW_BITS  = 6;
    localparam int EN_BIT   = 0;
    localparam int PRIO_LSB = 1;
    localparam int PRIO_MSB = 2;
    localparam int LEN_LSB  = 3;
    localparam int LEN_MSB  = 5;

    localparam logic [RW_BITS-1:0] RW_RST = 6'h07;

endpackage

// File: rtl/ctrl_reg_slice.sv
// One channel's registers: the 6-bit RW control register and the 8-bit
// RO margin sample, with the decoded en/prio/len fields taken from the flops.
// Ports: clk, rstn, wr_en/wdata (RW update), margin (sampled every cycle),
// rw_q/ro_q (register contents), en/prio/len (decoded fields).
module ctrl_reg_slice
    import mcdf_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_en,
    input  logic [RW_BITS-1:0] wdata,
    input  logic [7:0]         margin,
    output logic [RW_BITS-1:0] rw_q,
    output logic [7:0]         ro_q,
    output logic               en,
    output logic [1:0]         prio,
    output logic [2:0]         len
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rw_q <= RW_RST;
            ro_q <= '0;
        end else begin
            ro_q <= margin;
            if (wr_en) begin
                rw_q <= wdata;
            end
        end
    end

    assign en   = rw_q[EN_BIT];
    assign prio = rw_q[PRIO_MSB:PRIO_LSB];
    assign len  = rw_q[LEN_MSB:LEN_LSB];

endmodule

// File: rtl/ctrl_regs.sv
// Control/status register block for three channels, one command per cycle.
// Ports: clk, rstn, cmd/cmd_addr/cmd_data_w (command in), cmd_data_r
// (registered read data), cmd_err (error pulse), slvN_margin in,
// slvN_en/prio/len out.
module ctrl_regs
    import mcdf_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            cmd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data_w,
    output logic [DATA_WIDTH-1:0] cmd_data_r,
    output logic                  cmd_err,
    input  logic [7:0]            slv0_margin,
    input  logic [7:0]            slv1_margin,
    input  logic [7:0]            slv2_margin,
    output logic                  slv0_en,
    output logic                  slv1_en,
    output logic                  slv2_en,
    output logic [1:0]            slv0_prio,
    output logic [1:0]            slv1_prio,
    output logic [1:0]            slv2_prio,
    output logic [2:0]            slv0_len,
    output logic [2:0]            slv1_len,
    output logic [2:0]            slv2_len
);

    logic [2:0]         hit_rw;
    logic [2:0]         hit_ro;
    logic               is_rd;
    logic               is_wr;
    logic               is_rsv;
    logic [RW_BITS-1:0] rw_q [3];
    logic [7:0]         ro_q [3];
    logic [7:0]         margin [3];
    logic [DATA_WIDTH-1:0] rd_val;
    logic               rd_hit;

    // Only the low six write-data bits are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^cmd_data_w[DATA_WIDTH-1:RW_BITS];

    assign margin[0] = slv0_margin;
    assign margin[1] = slv1_margin;
    assign margin[2] = slv2_margin;

    assign is_rd  = (cmd == CMD_RD);
    assign is_wr  = (cmd == CMD_WR);
    assign is_rsv = (cmd == CMD_RSV);

    assign hit_rw[0] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV0_RW));
    assign hit_rw[1] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV1_RW));
    assign hit_rw[2] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV2_RW));
    assign hit_ro[0] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV0_RO));
    assign hit_ro[1] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV1_RO));
    assign hit_ro[2] = (cmd_addr == ADDR_WIDTH'(ADDR_SLV2_RO));

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        unique case (1'b1)
            hit_rw[0]: rd_val = DATA_WIDTH'(rw_q[0]);
            hit_rw[1]: rd_val = DATA_WIDTH'(rw_q[1]);
            hit_rw[2]: rd_val = DATA_WIDTH'(rw_q[2]);
            hit_ro[0]: rd_val = DATA_WIDTH'(ro_q[0]);
            hit_ro[1]: rd_val = DATA_WIDTH'(ro_q[1]);
            hit_ro[2]: rd_val = DATA_WIDTH'(ro_q[2]);
            default:   rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_data_r <= '0;
            cmd_err    <= 1'b0;
        end else begin
            if (is_rd) begin
                cmd_data_r <= rd_hit ? rd_val : '0;
            end
            cmd_err <= (is_wr && (hit_rw == 3'b000))
                     || (is_rd && !rd_hit)
                     || is_rsv;
        end
    end

    logic         en_v   [3];
    logic [1:0]   prio_v [3];
    logic [2:0]   len_v  [3];

    for (genvar i = 0; i < 3; i++) begin : g_slice
        ctrl_reg_slice u_slice (
            .clk    (clk),
            .rstn   (rstn),
            .wr_en  (is_wr && hit_rw[i]),
            .wdata  (cmd_data_w[RW_BITS-1:0]),
            .margin (margin[i]),
            .rw_q   (rw_q[i]),
            .ro_q   (ro_q[i]),
            .en     (en_v[i]),
            .prio   (prio_v[i]),
            .len    (len_v[i])
        );
    end

    assign slv0_en   = en_v[0];
    assign slv1_en   = en_v[1];
    assign slv2_en   = en_v[2];
    assign slv0_prio = prio_v[0];
    assign slv1_prio = prio_v[1];
    assign slv2_prio = prio_v[2];
    assign slv0_len  = len_v[0];
    assign slv1_len  = len_v[1];
    assign slv2_len  = len_v[2];

endmodule

// File: tb/tb_ctrl_regs.sv
// Directed self-checking bench for ctrl_regs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ctrl_regs;

    logic        clk;
    logic        rstn;
    logic [1:0]  cmd;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data_w;
    logic [31:0] cmd_data_r;
    logic        cmd_err;
    logic [7:0]  slv0_margin, slv1_margin, slv2_margin;
    logic        slv0_en, slv1_en, slv2_en;
    logic [1:0]  slv0_prio, slv1_prio, slv2_prio;
    logic [2:0]  slv0_len, slv1_len, slv2_len;

    int total = 0;
    int bad   = 0;

    ctrl_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd         (cmd),
        .cmd_addr    (cmd_addr),
        .cmd_data_w  (cmd_data_w),
        .cmd_data_r  (cmd_data_r),
        .cmd_err     (cmd_err),
        .slv0_margin (slv0_margin),
        .slv1_margin (slv1_margin),
        .slv2_margin (slv2_margin),
        .slv0_en     (slv0_en),
        .slv1_en     (slv1_en),
        .slv2_en     (slv2_en),
        .slv0_prio   (slv0_prio),
        .slv1_prio   (slv1_prio),
        .slv2_prio   (slv2_prio),
        .slv0_len    (slv0_len),
        .slv1_len    (slv1_len),
        .slv2_len    (slv2_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command for one cycle; returns at the next falling edge,
    // where the command's registered results are visible.
    task automatic issue(input logic [1:0] c, input logic [7:0] a,
                         input logic [31:0] d);
        cmd        = c;
        cmd_addr   = a;
        cmd_data_w = d;
        @(negedge clk);
        cmd        = 2'b00;
    endtask

    task automatic test_reset();
        cmd = 2'b00; cmd_addr = '0; cmd_data_w = '0;
        slv0_margin = 8'h11; slv1_margin = 8'h00; slv2_margin = 8'h13;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cmd_data_r !== 32'h0) begin bad++;
            $display("FAIL rst_data got=%h exp=0", cmd_data_r); end
        total++; if (cmd_err !== 1'b0) begin bad++;
            $display("FAIL rst_err got=%b exp=0", cmd_err); end
        total++; if ({slv0_en, slv0_prio, slv0_len} !== 6'b1_11_000) begin
            bad++; $display("FAIL rst_slv0 got=%b exp=111000",
                            {slv0_en, slv0_prio, slv0_len}); end
        total++; if ({slv1_en, slv1_prio, slv1_len,
                      slv2_en, slv2_prio, slv2_len} !== 12'b111000_111000)
        begin bad++; $display("FAIL rst_slv12 got=%b%b%b %b%b%b",
                slv1_en, slv1_prio, slv1_len, slv2_en, slv2_prio, slv2_len);
        end
        rstn = 1'b1;
        issue(2'b01, 8'h00, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0007) begin bad++;
            $display("FAIL rst_rd00 got=%h exp=00000007", cmd_data_r); end
    endtask

    task automatic test_write_read();
        issue(2'b10, 8'h04, 32'hFFFF_FF2A);
        total++; if ({slv1_en, slv1_prio, slv1_len} !== 6'b0_01_101) begin
            bad++; $display("FAIL wr04_fields got=%b exp=001101",
                            {slv1_en, slv1_prio, slv1_len}); end
        total++; if (cmd_data_r !== 32'h0000_0007 || cmd_err !== 1'b0) begin
            bad++; $display("FAIL wr04_side got=%h/%b exp=00000007/0",
                            cmd_data_r, cmd_err); end
        issue(2'b01, 8'h04, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_002A) begin bad++;
            $display("FAIL rd04 got=%h exp=0000002a", cmd_data_r); end
    endtask

    task automatic test_ro();
        issue(2'b01, 8'h18, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0013) begin bad++;
            $display("FAIL rd18 got=%h exp=00000013", cmd_data_r); end
        issue(2'b10, 8'h18, 32'h55);
        total++; if (cmd_err !== 1'b1) begin bad++;
            $display("FAIL wr18_err got=%b exp=1", cmd_err); end
        @(negedge clk);
        total++; if (cmd_err !== 1'b0) begin bad++;
            $display("FAIL wr18_err_len got=%b exp=0", cmd_err); end
        issue(2'b01, 8'h18, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0013) begin bad++;
            $display("FAIL rd18_again got=%h exp=00000013", cmd_data_r); end
        // Margin changes in the RD cycle itself: old sample is returned.
        slv0_margin = 8'h22;
        issue(2'b01, 8'h10, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0011) begin bad++;
            $display("FAIL rd10_lag got=%h exp=00000011", cmd_data_r); end
        issue(2'b01, 8'h10, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0022) begin bad++;
            $display("FAIL rd10_new got=%h exp=00000022", cmd_data_r); end
    endtask

    task automatic test_illegal();
        issue(2'b01, 8'h0C, 32'h0);
        total++; if (cmd_err !== 1'b1 || cmd_data_r !== 32'h0) begin bad++;
            $display("FAIL rd0c got=%b/%h exp=1/0", cmd_err, cmd_data_r); end
        @(negedge clk);
        total++; if (cmd_err !== 1'b0) begin bad++;
            $display("FAIL rd0c_len got=%b exp=0", cmd_err); end
        issue(2'b11, 8'h00, 32'hFFFF_FFFF);
        total++; if (cmd_err !== 1'b1 || cmd_data_r !== 32'h0) begin bad++;
            $display("FAIL rsv got=%b/%h exp=1/0", cmd_err, cmd_data_r); end
        @(negedge clk);
        total++; if (cmd_err !== 1'b0) begin bad++;
            $display("FAIL rsv_len got=%b exp=0", cmd_err); end
        issue(2'b10, 8'h0C, 32'h0);
        total++; if (cmd_err !== 1'b1) begin bad++;
            $display("FAIL wr0c got=%b exp=1", cmd_err); end
        total++; if ({slv0_en, slv0_prio, slv0_len, slv1_en, slv1_prio,
                      slv1_len, slv2_en, slv2_prio, slv2_len}
                     !== 18'b111000_001101_111000) begin bad++;
            $display("FAIL ill_rw got=%b%b%b %b%b%b %b%b%b",
                     slv0_en, slv0_prio, slv0_len, slv1_en, slv1_prio,
                     slv1_len, slv2_en, slv2_prio, slv2_len); end
    endtask

    task automatic test_back_to_back();
        cmd = 2'b10; cmd_addr = 8'h08; cmd_data_w = 32'h3F;
        @(negedge clk);
        total++; if ({slv2_en, slv2_prio, slv2_len} !== 6'b111111) begin
            bad++; $display("FAIL b2b_fields got=%b exp=111111",
                            {slv2_en, slv2_prio, slv2_len}); end
        issue(2'b01, 8'h08, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_003F || cmd_err !== 1'b0) begin
            bad++; $display("FAIL b2b_rd got=%h/%b exp=0000003f/0",
                            cmd_data_r, cmd_err); end
    endtask

    task automatic test_mid_reset();
        issue(2'b10, 8'h00, 32'h00);
        total++; if (slv0_en !== 1'b0) begin bad++;
            $display("FAIL wr00 got=%b exp=0", slv0_en); end
        cmd = 2'b01; cmd_addr = 8'h08;
        #2 rstn = 1'b0;
        #1;
        total++; if (slv0_en !== 1'b1 || slv0_prio !== 2'd3
                     || cmd_data_r !== 32'h0 || cmd_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst got=%b/%d/%h/%b exp=1/3/0/0",
                            slv0_en, slv0_prio, cmd_data_r, cmd_err); end
        @(negedge clk);
        total++; if (cmd_data_r !== 32'h0 || slv2_len !== 3'd0) begin bad++;
            $display("FAIL mid_rst_abort got=%h/%d exp=0/0",
                     cmd_data_r, slv2_len); end
        cmd = 2'b00;
        rstn = 1'b1;
        issue(2'b01, 8'h00, 32'h0);
        total++; if (cmd_data_r !== 32'h0000_0007) begin bad++;
            $display("FAIL post_rst_rd got=%h exp=00000007", cmd_data_r); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_ro();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
